// File: rtl/issue_ctrl.sv
// issue_ctrl -- single-entry in-order issue stage with register scoreboard.
//
// Accepts decoded instructions from decode, checks them against a 32-entry
// busy scoreboard for RAW/WAW hazards, and places them in a one-deep issue
// register toward execute. The controller holds issue after a branch or jump
// until that branch is resolved or the issue register is flushed.
//
// Parameter:
//   PAYLOAD_W   width of the opaque decoded-instruction payload
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready       decode handshake
//   in_rs1, in_rs2, in_rd     register indices of the presented instruction
//   in_use_rs1, in_use_rs2    source operands actually read
//   in_wr_reg                 instruction writes in_rd
//   in_is_br, in_is_jmp       control-transfer flags
//   in_payload                passed through unmodified
//   out_valid / out_ready     execute handshake
//   out_payload, out_rd, out_wr_reg   issue register contents
//   wb_valid, wb_rd           writeback completion, frees a scoreboard entry
//   br_resolve                pulse: outstanding branch/jump resolved
//   flush                     pulse: discard the issue register
//   busy_vec                  scoreboard (bit 0 always 0)
//   stall_cnt                 saturating count of hazard-stall cycles
//
// Build option:
//   ISSUE_WB_BYPASS_EN  when defined, a register being written back this cycle
//                       is already treated as free by the hazard check.

module issue_ctrl #(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic                 in_wr_reg,
    input  logic                 in_is_br,
    input  logic                 in_is_jmp,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [4:0]           out_rd,
    output logic                 out_wr_reg,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic                 br_resolve,
    input  logic                 flush,
    output logic [31:0]          busy_vec,
    output logic [15:0]          stall_cnt
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_BR_WAIT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [31:0]          busy_q, busy_d;
    logic [31:0]          busy_chk;
    logic                 out_valid_q, out_valid_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic [4:0]           out_rd_q, out_rd_d;
    logic                 out_wr_reg_q, out_wr_reg_d;
    logic [15:0]          stall_q, stall_d;
    logic                 hazard;
    logic                 accept;

    // Scoreboard view used by the hazard check.
    always_comb begin
        busy_chk = busy_q;
`ifdef ISSUE_WB_BYPASS_EN
        // Writeback this cycle frees its register for an issue this cycle.
        if (wb_valid) begin
            busy_chk[wb_rd] = 1'b0;
        end
`endif
    end

    // busy_q[0] is never set, so index 0 cannot raise a hazard.
    assign hazard = (in_use_rs1 & busy_chk[in_rs1])
                  | (in_use_rs2 & busy_chk[in_rs2])
                  | (in_wr_reg  & busy_chk[in_rd]);

    // A flush cycle must not accept: the issue register is being discarded.
    assign in_ready = (state_q == ST_RUN) & ~hazard & ~flush
                    & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        out_valid_d   = out_valid_q;
        out_payload_d = out_payload_q;
        out_rd_d      = out_rd_q;
        out_wr_reg_d  = out_wr_reg_q;
        stall_d       = stall_q;

        // Issue register: load on accept, drain when execute takes it.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_payload_d = in_payload;
            out_rd_d      = in_rd;
            out_wr_reg_d  = in_wr_reg;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clears first so that a same-edge set of the same index wins.
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (flush && out_valid_q && out_wr_reg_q) begin
            busy_d[out_rd_q] = 1'b0;
        end
        if (accept && in_wr_reg) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (accept && (in_is_br || in_is_jmp)) begin
                    state_d = ST_BR_WAIT;
                end
            end
            default: begin
                if (br_resolve || flush) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_payload_q <= '0;
            out_rd_q      <= '0;
            out_wr_reg_q  <= 1'b0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_payload_q <= out_payload_d;
            out_rd_q      <= out_rd_d;
            out_wr_reg_q  <= out_wr_reg_d;
            stall_q       <= stall_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_payload = out_payload_q;
    assign out_rd      = out_rd_q;
    assign out_wr_reg  = out_wr_reg_q;
    assign busy_vec    = busy_q;
    assign stall_cnt   = stall_q;

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 64, width of the opaque decoded-instruction payload carried to execute.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  decode presents an instruction; in_ready  output  1  issue_ctrl accepts it.
REQ-005 in_rs1, in_rs2, in_rd  input  5 each  register indices; in_use_rs1, in_use_rs2, in_wr_reg  input  1 each  operand-use and writeback flags.
REQ-006 in_is_br, in_is_jmp  input  1 each  control-transfer flags; in_payload  input  PAYLOAD_W  passed through unmodified.
REQ-007 out_valid  output  1; out_ready  input  1; out_payload  output  PAYLOAD_W; out_rd  output  5; out_wr_reg  output  1: issue register toward execute.
REQ-008 wb_valid  input  1; wb_rd  input  5: writeback completion, clears scoreboard entry.
REQ-009 br_resolve  input  1  one-cycle pulse, outstanding branch/jump resolved; flush  input  1  one-cycle pulse, discard issue register.
REQ-010 busy_vec  output  32  scoreboard; stall_cnt  output  16  saturating hazard-stall cycle count.

Function
REQ-011 Scoreboard bit n SHALL mean register n has an issued, un-written-back producer; bit 0 SHALL always read 0.
REQ-012 hazard = (in_use_rs1 & busy[in_rs1]) | (in_use_rs2 & busy[in_rs2]) | (in_wr_reg & busy[in_rd]) (RAW and WAW); index 0 never hazards.
REQ-013 in_ready = (state==RUN) & !hazard & (!out_valid | out_ready); combinational, independent of in_valid.
REQ-014 Accept (in_valid & in_ready) SHALL load out_payload/out_rd/out_wr_reg next edge and set out_valid=1; issue latency exactly 1 cycle.
REQ-015 out_valid and out fields SHALL hold stable while out_valid & !out_ready; back-to-back accepts with out_ready=1 SHALL sustain 1 instruction/cycle.
REQ-016 On accept with in_wr_reg=1 and in_rd!=0, busy[in_rd] SHALL set next edge.
REQ-017 wb_valid with wb_rd!=0 SHALL clear busy[wb_rd] next edge; same-edge set and clear of same index: set wins.
REQ-018 FSM states RUN, BR_WAIT: RUN->BR_WAIT on accept with in_is_br|in_is_jmp; BR_WAIT->RUN on br_resolve or flush; br_resolve in RUN ignored.
REQ-019 flush SHALL clear out_valid next edge, clear busy[out_rd] if the dropped entry had out_wr_reg=1 and out_rd!=0, force state RUN, and block accept that cycle (in_ready=0).
REQ-020 flush and wb_valid same cycle: both clears apply.
REQ-021 stall_cnt SHALL increment each cycle in_valid & !in_ready, saturating at 16'hFFFF; never cleared except by reset.

Reset
REQ-022 On rst low, asynchronously: out_valid=0, out_payload=0, out_rd=0, out_wr_reg=0, busy_vec=0, stall_cnt=0, state=RUN.
REQ-023 Reset mid-operation SHALL discard any held instruction and outstanding branch without further handshake; in_ready=1 in first cycle after release if out_ready unconstrained.

Configuration
REQ-024 Macro ISSUE_WB_BYPASS_EN: when defined, the hazard check SHALL treat busy[wb_rd] as clear in the same cycle wb_valid is asserted (writeback-to-issue bypass, 0-cycle); when undefined, the freed register is issuable only from the following cycle.

Verification
REQ-025 Reset, then accept ADDI rd=5 with out_ready=1 -> out_valid=1 next cycle, busy_vec=32'h20.
REQ-026 busy[5]=1, present in_rs1=5 in_use_rs1=1 for 3 cycles -> in_ready=0, stall_cnt=3; wb_valid wb_rd=5 -> accept same cycle with ISSUE_WB_BYPASS_EN, one cycle later without.
REQ-027 Accept BEQ -> state BR_WAIT, in_ready=0 until br_resolve; next instruction accepted cycle after pulse.
REQ-028 out_valid=1, out_rd=7, out_wr_reg=1, flush -> out_valid=0, busy[7]=0, state RUN next cycle.
REQ-029 Writes with in_rd=0 and wb_rd=0 -> busy_vec stays 0; in_rs1=0 never stalls.
REQ-030 Hold in_valid with permanent hazard 65540 cycles -> stall_cnt=16'hFFFF, no wrap.
